// File: rtl/loader_pkg.sv
// Shared types and defaults for the program loader.
// Holds the FSM state encoding and the default image size.
package loader_pkg;

   // Default number of program bytes written per load.
   localparam int RAM_BYTES_DEF = 16;

   // Default depth of the pin synchronizers.
   localparam int SYNC_STAGES_DEF = 2;

   // Loader FSM states.
   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_BYTE,
      S_WRITE,
      S_ACK,
      S_DONE
   } state_e;

   // Address width for a RAM of the given size (at least one bit).
   function automatic int addr_width(input int bytes);
      return (bytes > 1) ? $clog2(bytes) : 1;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin,
// with a single-cycle rising-edge pulse on the synchronized level.
module sync_edge #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o,
   output logic rise_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;
   logic              prev_q;

   // Shift the pin into the chain; bit 0 is the first sampling flop.
   always_comb begin
      sync_d    = sync_q << 1;
      sync_d[0] = d_i;
   end

   // Synchronizer chain plus the delayed copy used for edge detect.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= sync_q[STAGES-1];
      end
   end

   assign q_o    = sync_q[STAGES-1];
   assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/program_loader.sv
// Serial program loader: takes bytes from a host handshake,
// writes them to RAM and holds the CPU in reset meanwhile.
module program_loader
   import loader_pkg::*;
#(
   parameter int RAM_BYTES   = RAM_BYTES_DEF,
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   localparam int AW         = addr_width(RAM_BYTES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_req,
   input  logic          byte_valid,
   input  logic [7:0]    byte_in,
   output logic          byte_ack,
   output logic [AW-1:0] ram_addr,
   output logic [7:0]    ram_data,
   output logic          ram_we,
   output logic          cpu_hold,
   output logic          done,
   output logic          error,
   output logic [7:0]    checksum
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(RAM_BYTES - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [7:0]    data_q, data_d;
   logic [7:0]    csum_q, csum_d;
   logic          err_q, err_d;

   logic lreq_s;
   logic lreq_rise_unused;
   logic bval_s;
   logic bval_rise;

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_lreq (
      .clk    (clk),
      .rst    (rst),
      .d_i    (load_req),
      .q_o    (lreq_s),
      .rise_o (lreq_rise_unused)
   );

   sync_edge #(
      .STAGES (SYNC_STAGES)
   ) u_sync_bval (
      .clk    (clk),
      .rst    (rst),
      .d_i    (byte_valid),
      .q_o    (bval_s),
      .rise_o (bval_rise)
   );

   // Next-state logic; a dropped load request always wins as an abort.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      csum_d  = csum_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE: begin
            if (lreq_s) begin
               state_d = S_WAIT_BYTE;
               addr_d  = '0;
               csum_d  = '0;
               err_d   = 1'b0;
            end
         end
         S_WAIT_BYTE: begin
            if (!lreq_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (bval_rise) begin
               state_d = S_WRITE;
               data_d  = byte_in;
            end
         end
         S_WRITE: begin
            csum_d = csum_q + data_q;
            if (!lreq_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               state_d = S_ACK;
            end
         end
         S_ACK: begin
            if (!lreq_s) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else if (!bval_s) begin
               if (addr_q == LAST_ADDR) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_BYTE;
                  addr_d  = addr_q + AW'(1);
               end
            end
         end
         S_DONE: begin
            if (!lreq_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         csum_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         csum_q  <= csum_d;
         err_q   <= err_d;
      end
   end

   assign ram_we   = (state_q == S_WRITE);
   assign byte_ack = (state_q == S_ACK);
   assign cpu_hold = (state_q == S_WAIT_BYTE) ||
                     (state_q == S_WRITE) ||
                     (state_q == S_ACK);
   assign done     = (state_q == S_DONE);
   assign ram_addr = addr_q;
   assign ram_data = data_q;
   assign error    = err_q;
   assign checksum = csum_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected
// RAM writes, a negedge monitor pops and compares them.
module tb_program_loader;

   localparam int NB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       load_req;
   logic       byte_valid;
   logic [7:0] byte_in;
   logic       byte_ack;
   logic [3:0] ram_addr;
   logic [7:0] ram_data;
   logic       ram_we;
   logic       cpu_hold;
   logic       done;
   logic       error;
   logic [7:0] checksum;

   program_loader #(
      .RAM_BYTES   (NB),
      .SYNC_STAGES (2)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_req   (load_req),
      .byte_valid (byte_valid),
      .byte_in    (byte_in),
      .byte_ack   (byte_ack),
      .ram_addr   (ram_addr),
      .ram_data   (ram_data),
      .ram_we     (ram_we),
      .cpu_hold   (cpu_hold),
      .done       (done),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
      int at;
   } wr_t;

   wr_t expq[$];
   int  n_chk  = 0;
   int  n_fail = 0;
   int  model_sum;

   localparam int SIG_ACK  = 0;
   localparam int SIG_HOLD = 1;
   localparam int SIG_DONE = 2;

   task automatic check(input string name, input logic [31:0] act,
                        input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   function automatic logic sig(input int s);
      case (s)
         SIG_ACK:  return byte_ack;
         SIG_HOLD: return cpu_hold;
         default:  return done;
      endcase
   endfunction

   task automatic wait_sig(input int s, input logic v, input int lim,
                           input string name);
      int k = 0;
      while (sig(s) !== v && k < lim) begin
         @(negedge clk);
         k++;
      end
      check(name, sig(s), v);
   endtask

   // Monitor: every write strobe must match the head of the queue.
   wr_t e;
   always @(negedge clk) begin
      if (ram_we) begin
         if (expq.size() == 0) begin
            check("unexpected_we", 1, 0);
         end else begin
            e = expq.pop_front();
            check("we_addr", ram_addr, e.addr);
            check("we_data", ram_data, e.data);
            check("we_cycle", cyc, e.at);
         end
      end
   end

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, ram_addr, 0);
      check({tag, "_data"}, ram_data, 0);
      check({tag, "_we"}, ram_we, 0);
      check({tag, "_ack"}, byte_ack, 0);
      check({tag, "_hold"}, cpu_hold, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_err"}, error, 0);
      check({tag, "_sum"}, checksum, 0);
   endtask

   task automatic start_load();
      @(posedge clk);
      #1 load_req = 1'b1;
      wait_sig(SIG_HOLD, 1'b1, 10, "hold_rise");
      check("start_err", error, 0);
      check("start_addr", ram_addr, 0);
      check("start_sum", checksum, 0);
      model_sum = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int idx);
      int m;
      @(posedge clk);
      #1;
      byte_in    = b;
      byte_valid = 1'b1;
      expq.push_back('{idx, int'(b), cyc + 3});
      wait_sig(SIG_ACK, 1'b1, 20, "ack_rise");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
      m = cyc;
      wait_sig(SIG_ACK, 1'b0, 20, "ack_fall");
      check("ack_fall_cycle", cyc, m + 3);
      model_sum = (model_sum + int'(b)) % 256;
      repeat ($urandom_range(0, 2)) @(posedge clk);
   endtask

   task automatic full_load(input int mode);
      logic [7:0] b;
      for (int i = 0; i < NB; i++) begin
         if (mode == 0) b = 8'(i);
         else if (mode == 1) b = 8'hFF;
         else b = 8'($urandom_range(0, 255));
         send_byte(b, i);
      end
      wait_sig(SIG_DONE, 1'b1, 10, "done_rise");
      check("done_hold", cpu_hold, 0);
      check("done_addr", ram_addr, NB - 1);
      check("done_err", error, 0);
      check("done_sum", checksum, model_sum);
   endtask

   task automatic end_load();
      @(posedge clk);
      #1 load_req = 1'b0;
      wait_sig(SIG_DONE, 1'b0, 10, "done_fall");
      check("end_err", error, 0);
   endtask

   task automatic pulse_bval(input logic [7:0] b);
      @(posedge clk);
      #1;
      byte_in    = b;
      byte_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 byte_valid = 1'b0;
      repeat (4) @(posedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      int c;
      rst        = 1'b1;
      load_req   = 1'b0;
      byte_valid = 1'b0;
      byte_in    = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst0");
      rst = 1'b0;

      start_load();
      full_load(0);
      check("sum_0f", checksum, 'h78);
      end_load();

      start_load();
      full_load(1);
      check("sum_ff", checksum, 'hF0);
      pulse_bval(8'hA5);
      check("done_stays", done, 1);
      end_load();

      start_load();
      for (int i = 0; i < 5; i++) send_byte(8'($urandom_range(0, 255)), i);
      @(posedge clk);
      #1 load_req = 1'b0;
      wait_sig(SIG_HOLD, 1'b0, 10, "abort_hold");
      check("abort_err", error, 1);
      check("abort_done", done, 0);
      check("abort_addr", ram_addr, 5);
      check("abort_sum", checksum, model_sum);
      repeat (6) @(posedge clk);
      check("abort_err_sticky", error, 1);
      start_load();
      full_load(2);
      end_load();

      start_load();
      for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), i);
      @(posedge clk);
      #1;
      load_req   = 1'b0;
      byte_in    = 8'h3C;
      byte_valid = 1'b1;
      wait_sig(SIG_HOLD, 1'b0, 10, "simul_hold");
      check("simul_err", error, 1);
      check("simul_addr", ram_addr, 2);
      check("simul_sum", checksum, model_sum);
      repeat (3) @(posedge clk);
      #1 byte_valid = 1'b0;
      repeat (4) @(posedge clk);

      pulse_bval(8'h5A);
      start_load();
      b = 8'($urandom_range(0, 255));
      send_byte(b, 0);
      check("glitch_addr", ram_addr, 1);
      check("glitch_sum", checksum, model_sum);

      b = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
      byte_in    = b;
      byte_valid = 1'b1;
      c = cyc;
      expq.push_back('{1, int'(b), c + 3});
      repeat (4) @(negedge clk);
      check("rstw_we", ram_we, 1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rstw");
      rst        = 1'b0;
      byte_valid = 1'b0;
      load_req   = 1'b0;
      repeat (4) @(negedge clk);
      check("rstw_idle_we", ram_we, 0);
      check("rstw_idle_hold", cpu_hold, 0);

      check("queue_empty", expq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
